// File: rtl/mcdf_pkt_sched.sv
// Three-channel packet scheduler: priority/round-robin arbitration and beat-counted
// forwarding to the formatter. Define SCHED_STARVE_GUARD_EN to enable starvation promotion.
//
// state | meaning
// IDLE  | wait for formatter request and at least one requesting channel
// GRANT | winner id/length registered; one-cycle handoff, no data
// XFER  | forward beats of the granted channel until its beat count is reached
module mcdf_pkt_sched #(
  parameter int DATA_W    = 32,
  parameter int AGE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            slv_req_i,
  input  logic [2:0]            slv_val_i,
  input  logic [5:0]            slv_prio_i,
  input  logic [8:0]            slv_pkglen_i,
  input  logic [3*DATA_W-1:0]   slv_data_i,
  output logic [2:0]            a2s_ack_o,
  input  logic                  f2a_id_req_i,
  input  logic                  f2a_ack_i,
  output logic                  a2f_val_o,
  output logic [1:0]            a2f_id_o,
  output logic [2:0]            a2f_pkglen_sel_o,
  output logic [DATA_W-1:0]     a2f_data_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t      state_q, state_d;
  logic [1:0]  id_q, last_id_q, win_id, cand;
  logic [2:0]  sel_q;
  logic [5:0]  cnt_q, beats_m1;
  logic [2:0]  starved;
  logic [2:0]  eff_prio, win_prio;
  logic        win_found, arb_go, beat_go, last_beat, sel_val;

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

`ifdef SCHED_STARVE_GUARD_EN
  localparam logic [2:0] AGE_LIM = 3'(AGE_LIMIT);
  logic [2:0] age_q [3];

  // Ages move only on arbitration edges; an idle channel forgets its history at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < 3; n++) age_q[n] <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (!slv_req_i[n] || (arb_go && win_id == 2'(n)))
          age_q[n] <= '0;
        else if (arb_go && age_q[n] != 3'd7)
          age_q[n] <= age_q[n] + 3'd1;
      end
    end
  end

  always_comb begin
    starved = '0;
    for (int n = 0; n < 3; n++) starved[n] = slv_req_i[n] && (age_q[n] >= AGE_LIM);
  end
`else
  logic unused_age_limit;
  assign unused_age_limit = (AGE_LIMIT != 0);
  assign starved = '0;
`endif

  // Starved channels map to 0, others to 4..7; scanning in round-robin order with a
  // strict compare gives ties to the first channel after last_id.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    win_prio  = 3'd7;
    cand      = last_id_q;
    eff_prio  = 3'd7;
    for (int k = 0; k < 3; k++) begin
      cand     = next_ch(cand);
      eff_prio = starved[cand] ? 3'd0 : {1'b1, slv_prio_i[2*cand +: 2]};
      if (slv_req_i[cand] && (!win_found || eff_prio < win_prio)) begin
        win_found = 1'b1;
        win_id    = cand;
        win_prio  = eff_prio;
      end
    end
  end

  always_comb begin
    case (sel_q)
      3'd0:    beats_m1 = 6'd3;
      3'd1:    beats_m1 = 6'd7;
      3'd2:    beats_m1 = 6'd15;
      default: beats_m1 = 6'd31;
    endcase
  end

  assign sel_val   = slv_val_i[id_q];
  assign arb_go    = (state_q == IDLE) && f2a_id_req_i && (|slv_req_i);
  assign beat_go   = (state_q == XFER) && sel_val && f2a_ack_i;
  assign last_beat = beat_go && (cnt_q == beats_m1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      id_q      <= '0;
      sel_q     <= '0;
      last_id_q <= 2'd2;
    end else begin
      state_q <= state_d;
      if (arb_go) begin
        id_q  <= win_id;
        sel_q <= slv_pkglen_i[3*win_id +: 3];
        cnt_q <= '0;
      end else if (beat_go) begin
        cnt_q <= cnt_q + 6'd1;
      end
      if (last_beat) last_id_q <= id_q;
    end
  end

  // Outputs are forced low while reset is asserted so an abandoned packet sees no acks.
  always_comb begin
    state_d          = state_q;
    a2f_val_o        = 1'b0;
    a2s_ack_o        = '0;
    a2f_data_o       = '0;
    busy_o           = (state_q != IDLE) && !rst_i;
    a2f_id_o         = rst_i ? 2'd0 : id_q;
    a2f_pkglen_sel_o = rst_i ? 3'd0 : sel_q;
    case (state_q)
      IDLE:    if (arb_go) state_d = GRANT;
      GRANT:   state_d = XFER;
      XFER: begin
        if (last_beat) state_d = IDLE;
        if (!rst_i) begin
          a2f_val_o       = sel_val;
          a2f_data_o      = slv_data_i[DATA_W*id_q +: DATA_W];
          a2s_ack_o[id_q] = beat_go;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcdf_pkt_sched.sv
// Scoreboard bench for mcdf_pkt_sched: stimulus queues expected grants, a negedge
// monitor checks grant, beats, acks and data against a small reference model.
module tb_mcdf_pkt_sched;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [2:0]        slv_req_i = '0;
  logic [2:0]        slv_val_i = 3'b111;
  logic [5:0]        slv_prio_i = '0;
  logic [8:0]        slv_pkglen_i = '0;
  logic [3*DATA_W-1:0] slv_data_i = '0;
  logic [2:0]        a2s_ack_o;
  logic              f2a_id_req_i = 1'b0;
  logic              f2a_ack_i = 1'b1;
  logic              a2f_val_o;
  logic [1:0]        a2f_id_o;
  logic [2:0]        a2f_pkglen_sel_o;
  logic [DATA_W-1:0] a2f_data_o;
  logic              busy_o;

  always #5 clk_i = ~clk_i;

  mcdf_pkt_sched #(.DATA_W(DATA_W), .AGE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_req_i(slv_req_i), .slv_val_i(slv_val_i), .slv_prio_i(slv_prio_i),
    .slv_pkglen_i(slv_pkglen_i), .slv_data_i(slv_data_i), .a2s_ack_o(a2s_ack_o),
    .f2a_id_req_i(f2a_id_req_i), .f2a_ack_i(f2a_ack_i), .a2f_val_o(a2f_val_o),
    .a2f_id_o(a2f_id_o), .a2f_pkglen_sel_o(a2f_pkglen_sel_o),
    .a2f_data_o(a2f_data_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [1:0] id;
    logic [2:0] sel;
    int         beats;
    int         cycles;   // 0: XFER length not checked
  } grant_t;

  grant_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int grants_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] chan_data(input logic [1:0] ch);
    return 32'hD00D_0000 + 32'(ch) * 32'h0000_1111;
  endfunction

  // ---------------- monitor ----------------
  grant_t cur;
  bit     in_pkt = 1'b0;
  int     mon_beats = 0;
  int     mon_cycles = 0;
  logic   mon_val;

  initial begin : monitor
    forever begin
      @(negedge clk_i);
      if (busy_o && !in_pkt) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_grant: got id %0d, expected no grant", a2f_id_o);
          cur = '{2'd0, 3'd0, 0, 0};
        end else begin
          cur = exp_q.pop_front();
        end
        grants_seen++;
        check("grant_id", 64'(a2f_id_o), 64'(cur.id));
        check("grant_sel", 64'(a2f_pkglen_sel_o), 64'(cur.sel));
        check("grant_val", 64'(a2f_val_o), 64'd0);
        check("grant_ack", 64'(a2s_ack_o), 64'd0);
        in_pkt = 1'b1; mon_beats = 0; mon_cycles = 0;
      end else if (busy_o) begin
        mon_cycles++;
        mon_val = slv_val_i[cur.id];
        check("xfer_id", 64'(a2f_id_o), 64'(cur.id));
        check("xfer_sel", 64'(a2f_pkglen_sel_o), 64'(cur.sel));
        check("xfer_val", 64'(a2f_val_o), 64'(mon_val));
        check("xfer_ack", 64'(a2s_ack_o),
              64'((mon_val && f2a_ack_i) ? (3'b001 << cur.id) : 3'b000));
        if (mon_val) check("xfer_data", 64'(a2f_data_o), 64'(chan_data(cur.id)));
        if (mon_val && f2a_ack_i) mon_beats++;
      end else begin
        if (in_pkt) begin
          check("pkt_beats", 64'(mon_beats), 64'(cur.beats));
          if (cur.cycles != 0) check("xfer_cycles", 64'(mon_cycles), 64'(cur.cycles));
          in_pkt = 1'b0;
        end
        check("idle_val", 64'(a2f_val_o), 64'd0);
        check("idle_ack", 64'(a2s_ack_o), 64'd0);
        check("idle_data", 64'(a2f_data_o), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk_i);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_val"},  64'(a2f_val_o), 64'd0);
    check({tag, "_ack"},  64'(a2s_ack_o), 64'd0);
    check({tag, "_id"},   64'(a2f_id_o), 64'd0);
    check({tag, "_sel"},  64'(a2f_pkglen_sel_o), 64'd0);
    check({tag, "_data"}, 64'(a2f_data_o), 64'd0);
  endtask

  task automatic wait_grants(input int target);
    for (int i = 0; i < 3000 && grants_seen < target; i++) tick();
    check("grant_timeout", 64'(grants_seen >= target), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy_o; i++) tick();
    check("idle_timeout", 64'(busy_o), 64'd0);
    tick(); tick();
  endtask

  task automatic run_pkts(input int n);
    int target;
    target = grants_seen + n;
    f2a_id_req_i = 1'b1;
    wait_grants(target);
    f2a_id_req_i = 1'b0;
    wait_idle();
  endtask

  initial begin : stimulus
    int target;
    int n;
    for (int c = 0; c < 3; c++) slv_data_i[c*DATA_W +: DATA_W] = chan_data(2'(c));

    do_reset();
    check_all_zero("reset");

    // single requester ch1, 4 beats
    slv_req_i = 3'b010; slv_prio_i = '0; slv_pkglen_i = '0;
    exp_q.push_back('{2'd1, 3'd0, 4, 4});
    run_pkts(1);

    // equal-priority round robin between ch1 and ch2; ch0 lower priority; sel 5 -> 32
    do_reset();
    slv_req_i = 3'b111;
    slv_prio_i = {2'd1, 2'd1, 2'd2};
    slv_pkglen_i = {3'd5, 3'd1, 3'd0};
    exp_q.push_back('{2'd1, 3'd1, 8, 8});
    exp_q.push_back('{2'd2, 3'd5, 32, 32});
    exp_q.push_back('{2'd1, 3'd1, 8, 8});
    run_pkts(3);

    // ch2 sel 3 with ack toggling: 32 beats over 64 XFER cycles
    slv_req_i = 3'b100; slv_pkglen_i = {3'd3, 3'd0, 3'd0};
    exp_q.push_back('{2'd2, 3'd3, 32, 64});
    target = grants_seen + 1;
    f2a_ack_i = 1'b0; f2a_id_req_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      f2a_ack_i = ~f2a_ack_i;
      if (grants_seen >= target) f2a_id_req_i = 1'b0;
      if (grants_seen >= target && !busy_o) break;
    end
    f2a_id_req_i = 1'b0;
    f2a_ack_i = 1'b1;
    check("toggle_done", 64'(busy_o), 64'd0);
    tick(); tick();

    // mid-packet request drop and config change are ignored; valid gaps hold the count
    slv_req_i = 3'b001; slv_prio_i = '0; slv_pkglen_i = '0;
    exp_q.push_back('{2'd0, 3'd0, 4, 0});
    target = grants_seen + 1;
    f2a_id_req_i = 1'b1;
    wait_grants(target);
    f2a_id_req_i = 1'b0;
    slv_req_i = 3'b000; slv_pkglen_i = 9'd3; slv_prio_i = 6'd3;
    for (int i = 0; i < 100 && busy_o; i++) begin
      tick();
      slv_val_i[0] = ~slv_val_i[0];
    end
    check("gap_done", 64'(busy_o), 64'd0);
    slv_val_i = 3'b111;
    tick(); tick();

    // reset at beat 5 of an 8-beat packet
    slv_req_i = 3'b010; slv_prio_i = '0; slv_pkglen_i = {3'd0, 3'd1, 3'd0};
    exp_q.push_back('{2'd1, 3'd1, 4, 4});
    target = grants_seen + 1;
    f2a_id_req_i = 1'b1;
    wait_grants(target);
    f2a_id_req_i = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && n < 4; i++) begin
      @(negedge clk_i);
      if (a2s_ack_o[1]) n++;
    end
    check("pre_reset_acks", 64'(n), 64'd4);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_all_zero("abort");
    slv_req_i = 3'b111; slv_prio_i = '0; slv_pkglen_i = '0;
    exp_q.push_back('{2'd0, 3'd0, 4, 4});
    run_pkts(1);

    // starvation: ch0 low priority against ch1/ch2
    do_reset();
    slv_req_i = 3'b111; slv_prio_i = {2'd0, 2'd0, 2'd3}; slv_pkglen_i = '0;
    exp_q.push_back('{2'd1, 3'd0, 4, 4});
    exp_q.push_back('{2'd2, 3'd0, 4, 4});
    exp_q.push_back('{2'd1, 3'd0, 4, 4});
    exp_q.push_back('{2'd2, 3'd0, 4, 4});
`ifdef SCHED_STARVE_GUARD_EN
    exp_q.push_back('{2'd0, 3'd0, 4, 4});
`else
    exp_q.push_back('{2'd1, 3'd0, 4, 4});
`endif
    run_pkts(5);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
